v_univ_reg: RTL
===============

Name: v_univ_reg

Overview:
- Parametrised multi-mode register and successor to the single-bit async-preset/clear flip-flop primitive.
- Holds a WIDTH-bit word with synchronous preset/clear, parallel load, logical shift, rotate and up/down count.
- Primitive building block for datapath registers, serialisers and small counters in the modules/primitives tree.
- Asynchronous active-low reset forces a parametrised reset value.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2 (elaboration-time check, $error if violated).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on async reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low; q <= RST_VAL immediately on assertion.
- pre  input  1  synchronous preset, active-high; q <= all ones at next edge.
- clr  input  1  synchronous clear, active-high; q <= 0 at next edge.
- en  input  1  operation enable for mode actions; when low, q holds.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- si_lsb  input  1  serial bit entering at bit 0 on shift-left.
- si_msb  input  1  serial bit entering at bit WIDTH-1 on shift-right.
- q  output  WIDTH  registered state.
- so_msb  output  1  combinational copy of q[WIDTH-1].
- so_lsb  output  1  combinational copy of q[0].
- tc  output  1  combinational terminal-count flag.

Behaviour:
- Reset: rst_n low -> q = RST_VAL asynchronously; so_msb/so_lsb follow q; tc per its equation. Deassertion is synchronous to clk at system level; the first edge after release applies normal rules.
- Priority at each rising clk edge with rst_n high: pre > clr > en > mode.
  - pre=1 -> q = all ones, regardless of clr/en/mode.
  - else clr=1 -> q = 0, regardless of en/mode.
  - else en=0 -> hold.
  - else mode action.
- Mode encoding (en=1, pre=clr=0):
  - 000 hold.
  - 001 load: q = d.
  - 010 shift-left: q = {q[WIDTH-2:0], si_lsb}.
  - 011 shift-right: q = {si_msb, q[WIDTH-1:1]}.
  - 100 rotate-left: q = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate-right: q = {q[0], q[WIDTH-1:1]}.
  - 110 count up: q = q + 1, modulo 2^WIDTH.
  - 111 count down: q = q - 1, modulo 2^WIDTH.
- Latency: one cycle from input to q for all synchronous actions; no internal pipeline, so back-to-back operations every cycle.
- Wrap-around: all ones +1 -> 0; 0 -1 -> all ones; no sticky overflow.
- tc = en & ~pre & ~clr & ((mode==110 & q==all ones) | (mode==111 & q==0)). It is high exactly in the cycle where the next edge wraps the count. Cascade WIDTH-blocks by driving the next stage's en with tc.
- Shift/rotate use q before the edge; serial outputs reflect the pre-edge bit being shifted out.
- Unused serial inputs are ignored in non-shift modes.
- No X propagation from unselected inputs; d ignored unless mode==001 takes effect.

Test Plan:
- WIDTH=8, RST_VAL=8'hA5: assert rst_n=0 mid-cycle with clk idle -> q=8'hA5 without a clock edge. Release, en=0, 3 edges -> q stays 8'hA5.
- pre=1, clr=1, en=1, mode=001, d=8'h3C -> q=8'hFF. Next edge pre=0, clr=1 -> q=8'h00. Next edge clr=0, mode=001 -> q=8'h3C.
- q=8'h81, mode=010, si_lsb=1 -> q=8'h03, so_msb was 1 before the edge. mode=011, si_msb=0 from 8'h81 -> 8'h40. mode=100 from 8'h81 -> 8'h03. mode=101 from 8'h81 -> 8'hC0.
- Load 8'hFE, mode=110, en=1 -> q=FF with tc=1, then q=00 with tc=0. Load 8'h01, mode=111 -> q=00 with tc=1, then q=FF.
- Two WIDTH=4 instances cascaded (upper en = lower tc), count from 0 for 20 edges -> combined value 8'h14.
- Count up running at q=8'h10: rst_n pulse low between edges -> q=RST_VAL immediately. Counting resumes from RST_VAL on the first edge after release.

Source files
------------

// File: rtl/v_univ_reg.sv
// Multi-mode WIDTH-bit register: sync preset/clear, load, shift, rotate and up/down count.
// An asynchronous active-low reset forces RST_VAL; tc flags the cycle in which the next edge wraps the count.
module v_univ_reg #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si_lsb,
  input  logic             si_msb,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             tc
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("v_univ_reg: WIDTH must be >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] shl_fill;
  logic [WIDTH-1:0] shr_fill;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;

  // Neighbour wiring for shift/rotate; only the end bits differ between the two variants.
  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_shl
      assign shl_fill[gi] = q_reg[gi-1];
      assign rol_val[gi]  = q_reg[gi-1];
    end
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
      assign shr_fill[gi] = q_reg[gi+1];
      assign ror_val[gi]  = q_reg[gi+1];
    end
  endgenerate

  assign shl_fill[0]       = si_lsb;
  assign rol_val[0]        = q_reg[WIDTH-1];
  assign shr_fill[WIDTH-1] = si_msb;
  assign ror_val[WIDTH-1]  = q_reg[0];

  always_comb begin
    q_next = q_reg;
    if (pre) begin
      q_next = '1;
    end else if (clr) begin
      q_next = '0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: q_next = q_reg;
        MODE_LOAD: q_next = d;
        MODE_SHL:  q_next = shl_fill;
        MODE_SHR:  q_next = shr_fill;
        MODE_ROL:  q_next = rol_val;
        MODE_ROR:  q_next = ror_val;
        MODE_INC:  q_next = q_reg + 1'b1;
        MODE_DEC:  q_next = q_reg - 1'b1;
        default:   q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= RST_VAL;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q      = q_reg;
  assign so_msb = q_reg[WIDTH-1];
  assign so_lsb = q_reg[0];
  assign tc     = en & ~pre & ~clr &
                  (((mode == MODE_INC) & (q_reg == '1)) |
                   ((mode == MODE_DEC) & (q_reg == '0)));

endmodule
